// File: rtl/bram_burst_ctrl.sv
// Burst initiator for a 64x16 block RAM with a two-stage registered read path.
// Streams write beats into the RAM or tags returning read words with valid/last.
module bram_burst_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_do
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic              done_r;
  logic              cnt_one;
  logic              push;
  logic              pipe_last_out;

  assign cnt_one       = (cnt == {{ADDR_W{1'b0}}, 1'b1});
  assign push          = (state == S_READ);
  assign pipe_last_out = vld_pipe[RD_LAT-1] & last_pipe[RD_LAT-1];

  // Handshake and RAM-side signals decoded from the current state.
  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_di    = {DATA_W{1'b0}};
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        ram_addr = ptr;
        ram_di   = wr_data;
      end
      S_READ:  ram_addr = ptr;
      S_DRAIN: ram_addr = {ADDR_W{1'b0}};
      default: req_ready = 1'b0;
    endcase
  end

  // The output register only needs enabling while a read token is in flight.
  assign ram_en   = |vld_pipe;
  assign rd_valid = vld_pipe[RD_LAT-1];
  assign rd_last  = pipe_last_out;
  assign rd_data  = vld_pipe[RD_LAT-1] ? ram_do : {DATA_W{1'b0}};
  assign done     = done_r;

  // Burst sequencer: pointer, beat counter, read-token pipe and done pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      ptr       <= {ADDR_W{1'b0}};
      cnt       <= {(ADDR_W+1){1'b0}};
      vld_pipe  <= {RD_LAT{1'b0}};
      last_pipe <= {RD_LAT{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      vld_pipe[0]  <= push;
      last_pipe[0] <= push & cnt_one;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            ptr   <= req_addr;
            // A zero length encodes a full sweep of the address space.
            cnt   <= (req_len == {ADDR_W{1'b0}}) ? {1'b1, {ADDR_W{1'b0}}}
                                                 : {1'b0, req_len};
            state <= req_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            ptr <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt <= cnt - {{ADDR_W{1'b0}}, 1'b1};
            if (cnt_one) begin
              state  <= S_IDLE;
              done_r <= 1'b1;
            end
          end
        end
        S_READ: begin
          ptr <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt <= cnt - {{ADDR_W{1'b0}}, 1'b1};
          if (cnt_one) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pipe_last_out) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Scoreboard bench for bram_burst_ctrl with a behavioural two-stage RAM.
// Stimulus pushes expected writes, read beats and done cycles; a monitor pops and compares.
module tb_bram_burst_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [5:0]  req_addr = 6'd0;
  logic [5:0]  req_len = 6'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = 16'h0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_di;
  logic        ram_en;
  logic [15:0] ram_do = 16'h0;

  bram_burst_ctrl #(.ADDR_W(6), .DATA_W(16), .RD_LAT(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_en(ram_en),
    .ram_do(ram_do)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM: array read registered, then output register gated by en
  logic [15:0] mem [64];
  logic [15:0] q1 = 16'h0;
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    q1 <= mem[ram_addr];
    if (ram_en) ram_do <= q1;
  end

  typedef struct { logic [15:0] data; logic last; int cy; } rd_t;
  typedef struct { logic [5:0] addr; logic [15:0] data; } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];

  logic [15:0] exp_mem [64];
  logic [15:0] wdata [64];
  int compared = 0;
  int errors = 0;
  int we_count = 0;
  int acc_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something
  initial begin
    rd_t e;
    wr_t w;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (req_valid && req_ready) acc_count++;
        if (rd_valid) begin
          if (rd_q.size() == 0) chk("rd_unexpected", rd_valid, 1'b0);
          else begin
            e = rd_q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_last", rd_last, e.last);
            chk("rd_cycle", cyc, e.cy);
          end
        end else if (rd_last) chk("rd_last_novalid", rd_last, 1'b0);
        if (ram_we) begin
          we_count++;
          if (wr_q.size() == 0) chk("we_unexpected", ram_we, 1'b0);
          else begin
            w = wr_q.pop_front();
            chk("ram_addr", ram_addr, w.addr);
            chk("ram_di", ram_di, w.data);
          end
        end
        if (done) begin
          if (done_q.size() == 0) chk("done_unexpected", done, 1'b0);
          else chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_last"},  rd_last, 1'b0);
    chk({tag, "_rd_data"},  rd_data, 16'h0);
    chk({tag, "_done"},     done, 1'b0);
    chk({tag, "_ram_we"},   ram_we, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, 6'h0);
    chk({tag, "_ram_di"},   ram_di, 16'h0);
    chk({tag, "_ram_en"},   ram_en, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rd_q.size() != 0 || done_q.size() != 0 || wr_q.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", (n < 300), 1'b1);
    @(posedge CLK); #1;
  endtask

  // Called at posedge+1; returns the acceptance cycle with stimulus at next posedge+1
  task automatic issue_req(input logic wr, input logic [5:0] a, input int len, output int t);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = 6'(len);
    @(negedge CLK);
    chk("req_ready", req_ready, 1'b1);
    t = cyc;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input int len, input logic [15:0] pat, input bit busy);
    int t, k, acc, last_c;
    logic v;
    wr_t w;
    issue_req(1'b1, a, len, t);
    if (busy) begin
      req_valid = 1'b1; req_addr = 6'd40; req_write = 1'b0; req_len = 6'd1;
    end
    k = 0; acc = 0; last_c = 0;
    while (acc < len && k < 500) begin
      v = (k < 16) ? pat[k] : 1'b1;
      wr_valid = v;
      wr_data = v ? wdata[acc] : 16'hDEAD;
      if (v) begin
        w.addr = 6'(a + acc); w.data = wdata[acc];
        wr_q.push_back(w);
        exp_mem[w.addr] = w.data;
      end
      @(negedge CLK);
      if (v) begin
        chk("wr_ready", wr_ready, 1'b1);
        acc++;
        last_c = cyc;
      end
      @(posedge CLK); #1;
      k++;
    end
    wr_valid = 1'b0;
    done_q.push_back(last_c + 1);
    if (busy) begin
      rd_t e;
      @(negedge CLK);
      chk("busy_ready_in_done", req_ready, 1'b1);
      e.data = exp_mem[40]; e.last = 1'b1; e.cy = cyc + 3;
      rd_q.push_back(e);
      done_q.push_back(cyc + 4);
      @(posedge CLK); #1;
      req_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_read(input logic [5:0] a, input int len);
    int t;
    rd_t e;
    issue_req(1'b0, a, len, t);
    for (int i = 0; i < len; i++) begin
      e.data = exp_mem[6'(a + i)]; e.last = (i == len - 1); e.cy = t + 3 + i;
      rd_q.push_back(e);
    end
    done_q.push_back(t + len + 3);
    wait_idle();
  endtask

  initial begin
    int we0, acc0, t;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_req_ready", req_ready, 1'b1);
    check_idle_outputs("rst");
    @(posedge CLK); #1;

    // Basic write then read-back
    wdata[0] = 16'hA001; wdata[1] = 16'hA002; wdata[2] = 16'hA003; wdata[3] = 16'hA004;
    do_write(6'd10, 4, 16'hFFFF, 1'b0);
    do_read(6'd10, 4);

    // Address wrap at the top of the RAM
    wdata[0] = 16'd1; wdata[1] = 16'd2; wdata[2] = 16'd3;
    do_write(6'd62, 3, 16'hFFFF, 1'b0);
    chk("wrap_mem62", mem[62], 16'd1);
    chk("wrap_mem63", mem[63], 16'd2);
    chk("wrap_mem0",  mem[0],  16'd3);
    do_read(6'd62, 3);

    // Full 64-beat burst encoded as length 0
    for (int i = 0; i < 64; i++) wdata[i] = 16'(i) ^ 16'h5A5A;
    we0 = we_count;
    do_write(6'd0, 64, 16'hFFFF, 1'b0);
    chk("full_we_count", we_count - we0, 64);
    do_read(6'd0, 64);

    // Write stall pattern 1,0,0,1,1
    wdata[0] = 16'hB001; wdata[1] = 16'hB002; wdata[2] = 16'hB003;
    we0 = we_count;
    do_write(6'd5, 3, 16'hFFF9, 1'b0);
    chk("stall_we_count", we_count - we0, 3);
    do_read(6'd5, 3);

    // Request held high during a write burst
    wdata[0] = 16'hC001; wdata[1] = 16'hC002; wdata[2] = 16'hC003; wdata[3] = 16'hC004;
    acc0 = acc_count;
    do_write(6'd20, 4, 16'hFFFF, 1'b1);
    chk("busy_accept_count", acc_count - acc0, 2);

    // Reset one cycle into a len-8 read
    issue_req(1'b0, 6'd0, 8, t);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_rd_valid", rd_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/bram_burst_ctrl.md
# bram_burst_ctrl

Burst access controller that acts as the initiator for the team's 64x16 dual-port block RAM with its two-stage registered read path. It accepts one burst request at a time (start address, length, direction). It then streams write data into the RAM or streams read data out, tracking the RAM's two-cycle read latency so each returned word is tagged valid and last. It sits between a datapath master and RAM port 1 (`we`, `addr`, `DI`, `en`, `DO`).

## Interface
Parameters:
- `ADDR_W`, 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 16, RAM word width.
- `RD_LAT`, 2, clock edges from the address cycle to RAM output-register data valid.

Ports:
- `CLK`  in  1  Single clock; all logic is on the rising edge.
- `RST_N`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  1  Request offered.
- `req_ready`  out  1  High only in IDLE.
- `req_write`  in  1  1 means write burst; 0 means read burst.
- `req_addr`  in  ADDR_W  Start address.
- `req_len`  in  ADDR_W  Beat count; 0 encodes 2^ADDR_W (64).
- `wr_valid`  in  1  Write beat offered.
- `wr_ready`  out  1  High only in WRITE.
- `wr_data`  in  DATA_W  Write beat data.
- `rd_valid`  out  1  Read beat valid. There is no backpressure; the sink must accept every beat.
- `rd_data`  out  DATA_W  Read beat data, equal to `ram_do` when `rd_valid` is high.
- `rd_last`  out  1  Final read beat.
- `done`  out  1  One-cycle pulse at burst completion.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_di`  out  DATA_W  RAM write data.
- `ram_en`  out  1  RAM output-register enable.
- `ram_do`  in  DATA_W  RAM registered read data.

## Operation
- The state machine has four states: IDLE, WRITE, READ and DRAIN.
- Address pointer `ptr` (ADDR_W bits) and remaining-beat counter `cnt` (ADDR_W+1 bits) are internal registers.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `ptr`=`req_addr`.
  - Latch `cnt`=`req_len`, or 64 if `req_len` is 0.
  - Go to WRITE if `req_write`=1, otherwise go to READ.
- WRITE:
  - `wr_ready`=1.
  - `ram_we`=`wr_valid`, `ram_addr`=`ptr`, `ram_di`=`wr_data` (all combinational).
  - On each accepted beat: `ptr`+=1 (wrapping 63→0) and `cnt`-=1.
  - When the beat with `cnt`==1 is accepted, go to IDLE and register `done`=1 for the next cycle.
  - Gaps in `wr_valid` stall the burst with no RAM write.
- READ:
  - Every cycle: `ram_we`=0, `ram_addr`=`ptr`, `ptr`+=1 (wrapping), `cnt`-=1.
  - Push a token into an RD_LAT-deep valid shift pipe. The token carries a last flag, set when `cnt`==1.
  - After issuing the last address, go to DRAIN.
- DRAIN:
  - Issue no addresses; the pipe keeps shifting.
  - When the last-flagged token exits, go to IDLE and register `done`=1 for the next cycle.
- `ram_en`=1 whenever the pipe holds any token, and 0 otherwise.
- `rd_valid` and `rd_last` are the valid and last flags at the pipe output. `rd_data`=`ram_do`.
- `req_valid` outside IDLE is ignored, because `req_ready`=0. `wr_valid` outside WRITE is ignored.
- `ram_addr` is 0 in IDLE and DRAIN. `ram_di`=0 outside WRITE.

## Timing
- Reset (asynchronous, `RST_N`=0):
  - State goes to IDLE; `ptr`, `cnt` and the pipe are cleared.
  - `req_ready`=1 once reset is released. All other outputs are 0: `wr_ready`, `rd_valid`, `rd_last`, `rd_data`, `done`, `ram_we`, `ram_addr`, `ram_di`, `ram_en`.
  - RAM contents are unaffected.
- Reset mid-burst:
  - The burst is abandoned with no `done` pulse.
  - Any in-flight read beats are discarded and never appear on `rd_valid`.
- Request acceptance: the request is accepted in cycle T. The first write beat can be accepted, or the first read address issued, in cycle T+1.
- Read latency: the address is issued in cycle Ti; `rd_valid`/`rd_data` for it appear in cycle Ti+RAM_LAT, where RAM_LAT=RD_LAT=2. Beats are back-to-back, one per cycle.
- Completion:
  - Read bursts: `done` asserts the cycle after `rd_last`.
  - Write bursts: `done` asserts the cycle after the last accepted write beat.
  - `req_ready` is already 1 in the `done` cycle.
- Throughput:
  - Write bursts: N beats in N cycles with no `wr_valid` gaps, plus 1 cycle for request acceptance.
  - Read bursts: N+RD_LAT+1 cycles from acceptance to `done`.
- Read-after-write: a read burst that follows a write burst to the same address returns the new data.

## Test plan
- Write 4 words (0xA001..0xA004) at addr 10, then read 4 words at addr 10. Required: `rd_valid` high for 4 consecutive cycles with data A001..A004, starting 2 cycles after the first read address. `rd_last` high with A004. `done` high 1 cycle after `rd_last`.
- Wrap-around: write len 3 at addr 62 with data 1,2,3. Required: RAM[62]=1, RAM[63]=2, RAM[0]=3. A read of len 3 at addr 62 returns 1,2,3.
- Full burst: `req_len`=0 writes 64 words of value i^16'h5A5A. Required: exactly 64 `ram_we` pulses, and a full read of 64 words returns them in order with `rd_last` on beat 64.
- Write stall: toggle `wr_valid` as 1,0,0,1,1 for a len-3 burst. Required: exactly 3 RAM writes at consecutive addresses, and `done` the cycle after the 3rd accepted beat.
- Reset mid-read: assert `RST_N`=0 one cycle after a len-8 read begins. Required: all outputs go to 0 immediately, there is no `rd_valid` after release, and `req_ready`=1.
- Busy request: hold `req_valid` high with a different address during a len-4 write. Required: it is not accepted until IDLE, then accepted exactly once in the `done` cycle.
